// File: rtl/uivtc_detect_pkg.sv
// Shared definitions for the video timing detector: FSM state encoding and
// default parameter values.
package uivtc_detect_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMeas = 2'd1,
        StLock = 2'd2
    } state_e;

    localparam int unsigned DefCntW       = 12;
    localparam int unsigned DefLockFrames = 2;
    localparam int unsigned DefTimeoutW   = 24;

endpackage

// File: rtl/uivtc_detect_edge.sv
// Two-flop input register with rise/fall pulses taken from stage 1 against
// its previous value.
module uivtc_detect_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
        end
    end

    assign level_o = s1_q;
    assign rise_o  = s1_q & ~s2_q;
    assign fall_o  = ~s1_q & s2_q;

endmodule

// File: rtl/uivtc_detect.sv
// Video timing detector: measures vs/hs/de geometry, locks once consecutive frames
// agree, and emits pixel coordinates aligned with a 2-clock-delayed de.
module uivtc_detect
    import uivtc_detect_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned LOCK_FRAMES = DefLockFrames,
    parameter int unsigned TIMEOUT_W   = DefTimeoutW
) (
    input  logic             I_vtd_clk,
    input  logic             I_vtd_rst,
    input  logic             I_vtd_vs,
    input  logic             I_vtd_hs,
    input  logic             I_vtd_de,
    output logic [CNT_W-1:0] O_h_active,
    output logic [CNT_W-1:0] O_h_frame,
    output logic [CNT_W-1:0] O_h_sync,
    output logic [CNT_W-1:0] O_v_active,
    output logic [CNT_W-1:0] O_v_frame,
    output logic [CNT_W-1:0] O_v_sync,
    output logic             O_locked,
    output logic             O_timing_valid,
    output logic             O_de,
    output logic [CNT_W-1:0] O_x,
    output logic [CNT_W-1:0] O_y
);

    localparam int unsigned          SnapW     = 6 * CNT_W;
    localparam logic [CNT_W-1:0]     CntMax    = '1;
    localparam logic [CNT_W-1:0]     CntOne    = CNT_W'(1);
    localparam logic [TIMEOUT_W-1:0] WdMax     = '1;
    localparam logic [TIMEOUT_W-1:0] WdLast    = WdMax - TIMEOUT_W'(1);
    localparam logic [15:0]          MatchGoal = 16'(LOCK_FRAMES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    logic vs_lvl, vs_rise, unused_vs_fall;
    logic hs_lvl, hs_rise, hs_fall;
    logic de_lvl, de_rise, de_fall;

    uivtc_detect_edge u_edge_vs (
        .clk_i  (I_vtd_clk),
        .rst_i  (I_vtd_rst),
        .sig_i  (I_vtd_vs),
        .level_o(vs_lvl),
        .rise_o (vs_rise),
        .fall_o (unused_vs_fall)
    );

    uivtc_detect_edge u_edge_hs (
        .clk_i  (I_vtd_clk),
        .rst_i  (I_vtd_rst),
        .sig_i  (I_vtd_hs),
        .level_o(hs_lvl),
        .rise_o (hs_rise),
        .fall_o (hs_fall)
    );

    uivtc_detect_edge u_edge_de (
        .clk_i  (I_vtd_clk),
        .rst_i  (I_vtd_rst),
        .sig_i  (I_vtd_de),
        .level_o(de_lvl),
        .rise_o (de_rise),
        .fall_o (de_fall)
    );

    logic [CNT_W-1:0] h_clk_q, h_frame_q, hs_cnt_q, h_sync_q, de_cnt_q, h_active_q;
    logic [CNT_W-1:0] v_frame_q, v_sync_q, v_act_q, x_cnt_q, y_cnt_q;
    logic             sat_q, sat_set, snap_sat;
    logic [SnapW-1:0] snap, prev_q;
    logic             prev_vld_q, frame_match, lock_ok;
    logic [15:0]      match_q, match_nxt;
    logic [TIMEOUT_W-1:0] wd_q;
    state_e           state_q;

    // Any counter trying to step past its maximum taints the current frame.
    assign sat_set = (h_clk_q == CntMax && !hs_rise)
                   | (hs_cnt_q == CntMax && hs_lvl && !hs_rise)
                   | (de_cnt_q == CntMax && de_lvl && !de_rise)
                   | (v_frame_q == CntMax && hs_rise && !vs_rise)
                   | (v_sync_q == CntMax && hs_rise && vs_lvl && !vs_rise)
                   | (v_act_q == CntMax && de_fall && !vs_rise);

    assign snap        = {h_active_q, h_frame_q, h_sync_q, v_act_q, v_frame_q, v_sync_q};
    assign snap_sat    = sat_q | sat_set;
    assign frame_match = prev_vld_q && !snap_sat && (snap == prev_q);
    assign match_nxt   = match_q + 16'd1;
    assign lock_ok     = (LOCK_FRAMES == 1) ? !snap_sat : (frame_match && match_nxt == MatchGoal);

    always_ff @(posedge I_vtd_clk) begin
        if (I_vtd_rst) begin
            h_clk_q    <= '0;
            h_frame_q  <= '0;
            hs_cnt_q   <= '0;
            h_sync_q   <= '0;
            de_cnt_q   <= '0;
            h_active_q <= '0;
            v_frame_q  <= '0;
            v_sync_q   <= '0;
            v_act_q    <= '0;
            sat_q      <= 1'b0;
        end else begin
            h_clk_q <= hs_rise ? CntOne : sat_inc(h_clk_q);
            if (hs_rise) h_frame_q <= h_clk_q;
            if (hs_rise) hs_cnt_q <= CntOne;
            else if (hs_lvl) hs_cnt_q <= sat_inc(hs_cnt_q);
            if (hs_fall) h_sync_q <= hs_cnt_q;
            if (de_rise) de_cnt_q <= CntOne;
            else if (de_lvl) de_cnt_q <= sat_inc(de_cnt_q);
            if (de_fall) h_active_q <= de_cnt_q;
            // A coincident hs rise is line 1 of the new frame.
            if (vs_rise) begin
                v_frame_q <= hs_rise ? CntOne : '0;
                v_sync_q  <= hs_rise ? CntOne : '0;
                v_act_q   <= '0;
                sat_q     <= 1'b0;
            end else begin
                if (hs_rise) v_frame_q <= sat_inc(v_frame_q);
                if (hs_rise && vs_lvl) v_sync_q <= sat_inc(v_sync_q);
                if (de_fall) v_act_q <= sat_inc(v_act_q);
                sat_q <= sat_q | sat_set;
            end
        end
    end

    always_ff @(posedge I_vtd_clk) begin
        if (I_vtd_rst) begin
            state_q        <= StIdle;
            match_q        <= '0;
            prev_q         <= '0;
            prev_vld_q     <= 1'b0;
            wd_q           <= '0;
            O_locked       <= 1'b0;
            O_timing_valid <= 1'b0;
            {O_h_active, O_h_frame, O_h_sync, O_v_active, O_v_frame, O_v_sync} <= '0;
        end else begin
            O_timing_valid <= 1'b0;
            if (vs_rise) wd_q <= '0;
            else if (wd_q != WdMax) wd_q <= wd_q + TIMEOUT_W'(1);
            if (vs_rise) begin
                unique case (state_q)
                    StIdle: begin
                        state_q    <= StMeas;
                        match_q    <= '0;
                        prev_vld_q <= 1'b0;
                    end
                    StMeas: begin
                        prev_q     <= snap;
                        prev_vld_q <= 1'b1;
                        match_q    <= frame_match ? match_nxt : '0;
                        if (lock_ok) begin
                            state_q        <= StLock;
                            O_locked       <= 1'b1;
                            O_timing_valid <= 1'b1;
                            {O_h_active, O_h_frame, O_h_sync,
                             O_v_active, O_v_frame, O_v_sync} <= snap;
                        end
                    end
                    StLock: begin
                        prev_q <= snap;
                        if (!frame_match) begin
                            state_q  <= StMeas;
                            O_locked <= 1'b0;
                            match_q  <= '0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (wd_q == WdLast) begin
                state_q    <= StIdle;
                O_locked   <= 1'b0;
                match_q    <= '0;
                prev_vld_q <= 1'b0;
            end
        end
    end

    // Coordinates are registered alongside O_de, so they line up with it.
    always_ff @(posedge I_vtd_clk) begin
        if (I_vtd_rst) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            O_de    <= 1'b0;
            O_x     <= '0;
            O_y     <= '0;
        end else begin
            O_de <= de_lvl;
            if (de_lvl) begin
                x_cnt_q <= sat_inc(x_cnt_q);
                O_x     <= x_cnt_q;
                O_y     <= y_cnt_q;
            end else begin
                x_cnt_q <= '0;
                O_x     <= '0;
                O_y     <= '0;
            end
            if (vs_rise) y_cnt_q <= '0;
            else if (de_fall) y_cnt_q <= sat_inc(y_cnt_q);
        end
    end

endmodule

// File: tb/tb_uivtc_detect.sv
// Directed bench for uivtc_detect using small synthetic timings so that whole
// frames fit in a short run.
module tb_uivtc_detect;
    import uivtc_detect_pkg::*;

    localparam int unsigned CW = 12;
    localparam int unsigned TW = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vs = 1'b0;
    logic hs = 1'b0;
    logic de = 1'b0;

    logic [CW-1:0] h_active, h_frame, h_sync, v_active, v_frame, v_sync, ox, oy;
    logic          locked, tvalid, ode;
    logic [8*CW+2:0] all_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int tv_cnt   = 0;
    int frame_start = 0;
    int f_cyc    = -1;
    int drop_cyc = -1;
    int wd_start = 0;
    logic lock_seen  = 1'b0;
    logic first_pend = 1'b0;
    logic [CW-1:0] fx, fy, lx, ly;

    uivtc_detect #(
        .CNT_W      (CW),
        .LOCK_FRAMES(2),
        .TIMEOUT_W  (TW)
    ) dut (
        .I_vtd_clk     (clk),
        .I_vtd_rst     (rst),
        .I_vtd_vs      (vs),
        .I_vtd_hs      (hs),
        .I_vtd_de      (de),
        .O_h_active    (h_active),
        .O_h_frame     (h_frame),
        .O_h_sync      (h_sync),
        .O_v_active    (v_active),
        .O_v_frame     (v_frame),
        .O_v_sync      (v_sync),
        .O_locked      (locked),
        .O_timing_valid(tvalid),
        .O_de          (ode),
        .O_x           (ox),
        .O_y           (oy)
    );

    assign all_out = {h_active, h_frame, h_sync, v_active, v_frame, v_sync,
                      locked, tvalid, ode, ox, oy};

    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, observe outputs on the falling edge.
    task automatic cyc(input logic v, input logic h, input logic d);
        vs = v;
        hs = h;
        de = d;
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        if (tvalid === 1'b1) tv_cnt++;
        if (locked === 1'b1) lock_seen = 1'b1;
        if (ode === 1'b1) begin
            if (first_pend) begin
                first_pend = 1'b0;
                fx = ox;
                fy = oy;
                f_cyc = cyc_n;
            end
            lx = ox;
            ly = oy;
        end
    endtask

    task automatic frame(input int hf, input int hsw, input int ha, input int hbp,
                         input int vsw, input int va, input int vbp,
                         input int de_long, input int nlines);
        logic d;
        first_pend = 1'b1;
        frame_start = cyc_n;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < hf; p++) begin
                if (de_long > 0)
                    d = (l * hf + p >= vbp * hf) && (l * hf + p < vbp * hf + de_long);
                else
                    d = (l >= vbp) && (l < vbp + va) && (p >= hbp) && (p < hbp + ha);
                cyc(l < vsw, p < hsw, d);
            end
        end
    endtask

    // Mode A: 8x4 active, Hf 14, hs 2, Vf 8, vs 2.  Mode B: 6x3, Hf 12, hs 3, Vf 7, vs 1.
    task automatic frame_a(input int nlines);
        frame(14, 2, 8, 4, 2, 4, 3, 0, nlines);
    endtask

    task automatic frame_b(input int nlines);
        frame(12, 3, 6, 4, 1, 3, 2, 0, nlines);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", all_out);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_locked: got %b, want 0", locked);
        end
    endtask

    task automatic test_lock;
        tv_cnt = 0;
        frame_a(8);
        frame_a(8);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b, want 0", locked); end
        n_checks++;
        if (tv_cnt !== 0) begin n_fail++; $display("FAIL tv_early: got %0d, want 0", tv_cnt); end
        frame_a(8);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_a: got %b, want 1", locked); end
        n_checks++;
        if (tv_cnt !== 1) begin n_fail++; $display("FAIL tv_a: got %0d, want 1", tv_cnt); end
        n_checks++;
        if (h_active !== 12'd8) begin n_fail++; $display("FAIL h_active_a: got %0d, want 8", h_active); end
        n_checks++;
        if (h_frame !== 12'd14) begin n_fail++; $display("FAIL h_frame_a: got %0d, want 14", h_frame); end
        n_checks++;
        if (h_sync !== 12'd2) begin n_fail++; $display("FAIL h_sync_a: got %0d, want 2", h_sync); end
        n_checks++;
        if (v_active !== 12'd4) begin n_fail++; $display("FAIL v_active_a: got %0d, want 4", v_active); end
        n_checks++;
        if (v_frame !== 12'd8) begin n_fail++; $display("FAIL v_frame_a: got %0d, want 8", v_frame); end
        n_checks++;
        if (v_sync !== 12'd2) begin n_fail++; $display("FAIL v_sync_a: got %0d, want 2", v_sync); end
    endtask

    task automatic test_pixels;
        f_cyc = -1;
        frame_a(8);
        n_checks++;
        if (fx !== 12'd0) begin n_fail++; $display("FAIL first_x: got %0d, want 0", fx); end
        n_checks++;
        if (fy !== 12'd0) begin n_fail++; $display("FAIL first_y: got %0d, want 0", fy); end
        // First de is driven at frame clock 3*14+4; O_de follows two edges later.
        n_checks++;
        if (f_cyc - frame_start !== 48) begin
            n_fail++;
            $display("FAIL first_pix_latency: got %0d, want 48", f_cyc - frame_start);
        end
        n_checks++;
        if (lx !== 12'd7) begin n_fail++; $display("FAIL last_x: got %0d, want 7", lx); end
        n_checks++;
        if (ly !== 12'd3) begin n_fail++; $display("FAIL last_y: got %0d, want 3", ly); end
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold: got %b, want 1", locked); end
        n_checks++;
        if (tv_cnt !== 1) begin n_fail++; $display("FAIL tv_hold: got %0d, want 1", tv_cnt); end
    endtask

    task automatic test_mode_switch;
        frame_a(4);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_partial: got %b, want 1", locked); end
        frame_b(7);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL unlock_b1: got %b, want 0", locked); end
        n_checks++;
        if (h_active !== 12'd8) begin n_fail++; $display("FAIL held_h_active: got %0d, want 8", h_active); end
        n_checks++;
        if (v_frame !== 12'd8) begin n_fail++; $display("FAIL held_v_frame: got %0d, want 8", v_frame); end
        frame_b(7);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL unlock_b2: got %b, want 0", locked); end
        frame_b(7);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_b: got %b, want 1", locked); end
        n_checks++;
        if (tv_cnt !== 2) begin n_fail++; $display("FAIL tv_b: got %0d, want 2", tv_cnt); end
        n_checks++;
        if (h_active !== 12'd6) begin n_fail++; $display("FAIL h_active_b: got %0d, want 6", h_active); end
        n_checks++;
        if (h_frame !== 12'd12) begin n_fail++; $display("FAIL h_frame_b: got %0d, want 12", h_frame); end
        n_checks++;
        if (h_sync !== 12'd3) begin n_fail++; $display("FAIL h_sync_b: got %0d, want 3", h_sync); end
        n_checks++;
        if (v_active !== 12'd3) begin n_fail++; $display("FAIL v_active_b: got %0d, want 3", v_active); end
        n_checks++;
        if (v_frame !== 12'd7) begin n_fail++; $display("FAIL v_frame_b: got %0d, want 7", v_frame); end
        n_checks++;
        if (v_sync !== 12'd1) begin n_fail++; $display("FAIL v_sync_b: got %0d, want 1", v_sync); end
    endtask

    task automatic test_watchdog;
        frame_b(7);
        wd_start = frame_start;
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_pre_wd: got %b, want 1", locked); end
        drop_cyc = -1;
        for (int i = 0; i < 9000 && drop_cyc < 0; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (locked === 1'b0) drop_cyc = cyc_n;
        end
        // The vs rise is acted on at frame clock 2; expiry follows 2^TW-1 clocks later.
        n_checks++;
        if (drop_cyc - wd_start !== 2 + (2 ** TW - 1)) begin
            n_fail++;
            $display("FAIL wd_drop: got %0d, want %0d", drop_cyc - wd_start, 2 + (2 ** TW - 1));
        end
        n_checks++;
        if (dut.state_q !== StIdle) begin
            n_fail++;
            $display("FAIL wd_state: got %0d, want %0d", dut.state_q, StIdle);
        end
    endtask

    task automatic test_mid_reset;
        frame_a(8);
        frame_a(8);
        frame_a(8);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_pre_rst: got %b, want 1", locked); end
        frame_a(5);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        n_checks++;
        if (all_out !== '0) begin n_fail++; $display("FAIL mid_rst_outputs: got %h, want 0", all_out); end
        tv_cnt = 0;
        frame_a(8);
        frame_a(8);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b, want 0", locked); end
        frame_a(8);
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %b, want 1", locked); end
        n_checks++;
        if (tv_cnt !== 1) begin n_fail++; $display("FAIL relock_tv: got %0d, want 1", tv_cnt); end
        n_checks++;
        if (h_active !== 12'd8) begin n_fail++; $display("FAIL relock_h_active: got %0d, want 8", h_active); end
    endtask

    task automatic test_saturation;
        rst = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        lock_seen = 1'b0;
        // 420 lines of Hf 14 with one 5000-clock de run starting on line 5.
        repeat (4) frame(14, 2, 0, 0, 2, 0, 5, 5000, 420);
        n_checks++;
        if (lock_seen !== 1'b0) begin n_fail++; $display("FAIL sat_lock: got %b, want 0", lock_seen); end
        n_checks++;
        if (h_active !== 12'd0) begin n_fail++; $display("FAIL sat_published: got %0d, want 0", h_active); end
        n_checks++;
        if (dut.h_active_q !== 12'd4095) begin
            n_fail++;
            $display("FAIL sat_h_active: got %0d, want 4095", dut.h_active_q);
        end
        n_checks++;
        if (lx !== 12'd4095) begin n_fail++; $display("FAIL sat_x: got %0d, want 4095", lx); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_mode_switch();
        test_watchdog();
        test_mid_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
